// File: rtl/piso_shift_tx.sv
// Framed PISO transmitter: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Define PIPO_TX_PARITY_EN to insert the parity bit between the last data bit and the stop bit.
module piso_shift_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                sout_q, sout_d;
  logic                done_q, done_d;
  logic                tick;
`ifdef PIPO_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign tick = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
`ifdef PIPO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          shreg_d = din;
          div_d   = '0;
          bit_d   = '0;
          state_d = StStart;
`ifdef PIPO_TX_PARITY_EN
          parity_d = ^din;
`endif
        end
      end
      StStart: if (tick) state_d = StData;
      StData: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef PIPO_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
`ifdef PIPO_TX_PARITY_EN
      StParity: if (tick) state_d = StStop;
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The line is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    sout_d = 1'b1;
    unique case (state_d)
      StStart:  sout_d = 1'b0;
      StData:   sout_d = shreg_d[0];
`ifdef PIPO_TX_PARITY_EN
      StParity: sout_d = parity_d;
`endif
      default:  sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
`ifdef PIPO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign load_ready = (state_q == StIdle);
  assign busy       = ~load_ready;
  assign sout       = sout_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: accepted words are queued, a negedge monitor checks
// every cycle of the line against a frame built from the word.
module tb_piso_shift_tx;

  localparam int unsigned W = 8;
`ifdef PIPO_TX_PARITY_EN
  localparam int unsigned C   = 1;
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned C   = 4;
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned F = (W + 2 + PAR) * C;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, sout, busy, done;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;
  bit mon_in_frame = 0;
  bit mon_done_due = 0;
  int pos = 0;

  piso_shift_tx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  // Frame as a bit list: start, payload LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [W-1:0] w, input int p);
    logic [W+2:0] frame;
    int n;
    n = 0;
    frame = '0;
    frame[n] = 1'b0; n++;
    for (int i = 0; i < int'(W); i++) begin
      frame[n] = w[i]; n++;
    end
    if (PAR != 0) begin
      frame[n] = ^w; n++;
    end
    frame[n] = 1'b1;
    return frame[(p - 1) / int'(C)];
  endfunction

  always @(posedge clk) begin
    if (rstn && load_valid && load_ready) exp_q.push_back(din);
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_sout", sout, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", load_ready, 1'b1);
      mon_in_frame = 0;
      mon_done_due = 0;
      pos = 0;
    end else if (mon_done_due) begin
      chk("done_pulse", done, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_ready", load_ready, 1'b1);
      chk("done_sout", sout, 1'b1);
      mon_done_due = 0;
    end else begin
      if (!mon_in_frame && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        mon_in_frame = 1;
        pos = 0;
      end
      if (mon_in_frame) begin
        pos++;
        chk("frame_sout", sout, exp_bit(cur, pos));
        chk("frame_busy", busy, 1'b1);
        chk("frame_ready", load_ready, 1'b0);
        chk("frame_done", done, 1'b0);
        if (pos == int'(F)) begin
          mon_in_frame = 0;
          mon_done_due = 1;
        end
      end else begin
        chk("idle_sout", sout, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", load_ready, 1'b1);
        chk("idle_done", done, 1'b0);
      end
    end
  end

  // Holds load_valid until an edge where the DUT is ready; returns 1 ns after the accept edge.
  task automatic send(input logic [W-1:0] w);
    bit got;
    got = 0;
    din = w;
    load_valid = 1'b1;
    for (int i = 0; i < int'(4 * F + 20) && !got; i++) begin
      @(negedge clk);
      #1;
      got = load_ready && rstn;
      @(posedge clk);
    end
    #1;
    load_valid = 1'b0;
    din = W'($urandom);
    chk("send_accept", got, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < int'(4 * F + 20) && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = !mon_in_frame && !mon_done_due && exp_q.size() == 0;
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      load_valid = 1'($urandom);
      din = W'($urandom);
    end
    @(negedge clk);
    load_valid = 1'b0;
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(8'hA5);
    wait_idle();
    send(8'h3C);
    send(8'hFF);
    wait_idle();

    // Load offered mid-frame must be ignored.
    send(8'hA5);
    repeat (9) @(posedge clk);
    #1;
    din = 8'h00;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // Abort mid-frame with an asynchronous reset.
    send(8'h5A);
    repeat (14) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_sout", sout, 1'b1);
    chk("async_rst_ready", load_ready, 1'b1);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    send(8'h81);
    wait_idle();

    send(8'h07);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
